sw_debounce_port: RTL and testbench
===================================

SW_DEBOUNCE_PORT -- requirements
Module: sw_debounce_port

Interface
REQ-001 Parameter N, 8, number of switch inputs (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced bit changes (>=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_sw  input  N  raw asynchronous switch levels.
REQ-006 i_addr  input  2  register word offset, already decoded from the CPU bus window.
REQ-007 i_rd  input  1  read strobe, one cycle.
REQ-008 i_wr  input  1  write strobe, one cycle.
REQ-009 i_wrdata  input  16  write data.
REQ-010 o_rddata  output  16  read data, registered.
REQ-011 o_sw  output  N  debounced switch levels.
REQ-012 o_irq  output  1  level interrupt, high while any unmasked edge flag is set.

Function
REQ-013 Each i_sw bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-014 Per bit, a counter SHALL clear on every edge where sync2 equals o_sw and increment where they differ.
REQ-015 o_sw bit SHALL toggle, and its counter clear, on the edge where the counter would reach DEBOUNCE_CYCLES; counter width SHALL be clog2(DEBOUNCE_CYCLES+1) and SHALL never wrap.
REQ-016 Latency: i_sw level stable from edge k SHALL appear on o_sw after edge k+DEBOUNCE_CYCLES+1; any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL not change o_sw.
REQ-017 Register map: offset 0 DATA (RO) = {zero-pad, o_sw}; offset 1 EDGE (N bits, write-1-to-clear); offset 2 MASK (N bits, RW); offset 3 reserved.
REQ-018 EDGE bit SHALL set on the edge where its o_sw bit goes 0->1; 1->0 transitions SHALL not set it.
REQ-019 Write to offset 1 SHALL clear EDGE bits where i_wrdata is 1; same-cycle set and clear of one bit: set wins.
REQ-020 Write to offset 2 SHALL load MASK from i_wrdata[N-1:0]; writes to offsets 0 and 3 SHALL be ignored.
REQ-021 Read: o_rddata SHALL load the addressed register, zero-padded to 16 bits, on the edge where i_rd is high (one-cycle latency, matching mem4k); offset 3 reads 0.
REQ-022 o_rddata SHALL hold its value on cycles without i_rd.
REQ-023 i_rd and i_wr together SHALL perform the write and return the pre-write register value.
REQ-024 o_irq SHALL be combinational |(EDGE & MASK), with no extra latency beyond the registers.

Reset
REQ-025 While reset is high at a clock edge: sync1, sync2, all counters, o_sw, EDGE, MASK, o_rddata SHALL be 0; o_irq therefore 0.
REQ-026 Reset asserted mid-debounce SHALL discard partial counts; reset has priority over i_rd/i_wr.
REQ-027 Switches already high at reset release SHALL debounce from 0 normally and set their EDGE bits.

Verification (bench uses N=8, DEBOUNCE_CYCLES=4)
REQ-028 i_sw 0x00->0x08 held steady -> o_sw=0x08 exactly 5 edges after first sampling edge, EDGE=0x08.
REQ-029 i_sw bit 5 pulsed high for 3 cycles then low -> o_sw stays 0x00, EDGE stays 0x00.
REQ-030 EDGE=0x08, MASK write 0x08 -> o_irq=1; write offset 1 data 0x08 -> EDGE=0x00, o_irq=0 next cycle.
REQ-031 Read offset 0 with o_sw=0x20 -> o_rddata=0x0020 one edge after i_rd; read offset 3 -> 0x0000.
REQ-032 Write-1-to-clear of bit 3 on the same edge bit 3 rises -> EDGE bit 3 remains 1.
REQ-033 Reset asserted 2 cycles into a 0->1 debounce of bit 0 -> o_sw=0x00, counters 0; after release with i_sw=0x01, o_sw=0x01 after 5 edges.

Source files
------------

// File: rtl/sw_debounce_port.sv
// Debounced switch input port with rising-edge flags, interrupt mask and a
// small four-word register window for a CPU bus.
module sw_debounce_port #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] i_sw,
    input  logic [1:0]   i_addr,
    input  logic         i_rd,
    input  logic         i_wr,
    input  logic [15:0]  i_wrdata,
    output logic [15:0]  o_rddata,
    output logic [N-1:0] o_sw,
    output logic         o_irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  sync1;
    logic [N-1:0]  sync2;
    logic [N-1:0]  edge_q;
    logic [N-1:0]  mask_q;
    logic [N-1:0]  toggle;
    logic [N-1:0]  rise;
    logic [N-1:0]  edge_clr;
    logic [N-1:0]  edge_next;
    logic [CW-1:0] cnt [N];
    logic [15:0]   rd_val;
    logic          unused_wrdata;

    assign unused_wrdata = ^i_wrdata;

    // A bit flips on the edge its counter would reach DEBOUNCE_CYCLES, so the
    // counter itself only ever holds 0..DEBOUNCE_CYCLES-1.
    always_comb begin
        toggle = '0;
        for (int unsigned i = 0; i < N; i++) begin
            toggle[i] = (sync2[i] != o_sw[i]) && (cnt[i] == CNT_LAST);
        end
    end

    assign rise      = toggle & ~o_sw;
    assign edge_clr  = (i_wr && i_addr == 2'd1) ? i_wrdata[N-1:0] : '0;
    assign edge_next = (edge_q & ~edge_clr) | rise;

    always_comb begin
        rd_val = '0;
        case (i_addr)
            2'd0:    rd_val[N-1:0] = o_sw;
            2'd1:    rd_val[N-1:0] = edge_q;
            2'd2:    rd_val[N-1:0] = mask_q;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            o_sw     <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            o_rddata <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= i_sw;
            sync2  <= sync1;
            o_sw   <= o_sw ^ toggle;
            edge_q <= edge_next;
            for (int unsigned i = 0; i < N; i++) begin
                if (sync2[i] == o_sw[i] || toggle[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            if (i_wr && i_addr == 2'd2) begin
                mask_q <= i_wrdata[N-1:0];
            end
            if (i_rd) begin
                o_rddata <= rd_val;
            end
        end
    end

    assign o_irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_sw_debounce_port.sv
// Randomized bench for sw_debounce_port with a window-based reference model
// plus directed literal checks of the key debounce and register behaviours.
module tb_sw_debounce_port;

    localparam int N = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] i_sw = '0;
    logic [1:0]   i_addr = '0;
    logic         i_rd = 1'b0;
    logic         i_wr = 1'b0;
    logic [15:0]  i_wrdata = '0;
    logic [15:0]  o_rddata;
    logic [N-1:0] o_sw;
    logic         o_irq;

    int checks = 0;
    int failures = 0;
    logic started = 1'b0;

    sw_debounce_port #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .i_sw(i_sw), .i_addr(i_addr), .i_rd(i_rd),
        .i_wr(i_wr), .i_wrdata(i_wrdata), .o_rddata(o_rddata), .o_sw(o_sw),
        .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%04h required=0x%04h", name, act, exp);
        end
    endtask

    // Reference model: a debounced bit flips once the last D synchronized
    // samples all disagree with it; hist[0] is the newest raw sample.
    logic [N-1:0] m_sw, m_edge, m_mask;
    logic [15:0]  m_rd;
    logic [N-1:0] hist [0:D];

    always @(posedge clk) begin : model
        logic [N-1:0] tog;
        logic [N-1:0] clr;
        logic [15:0]  rv;
        if (reset) begin
            m_sw = '0; m_edge = '0; m_mask = '0; m_rd = '0;
            for (int j = 0; j <= D; j++) hist[j] = '0;
        end else begin
            for (int b = 0; b < N; b++) begin
                tog[b] = 1'b1;
                for (int j = 1; j <= D; j++)
                    if (hist[j][b] == m_sw[b]) tog[b] = 1'b0;
            end
            rv = '0;
            case (i_addr)
                2'd0: rv[N-1:0] = m_sw;
                2'd1: rv[N-1:0] = m_edge;
                2'd2: rv[N-1:0] = m_mask;
                default: rv = '0;
            endcase
            if (i_rd) m_rd = rv;
            clr = (i_wr && i_addr == 2'd1) ? i_wrdata[N-1:0] : '0;
            m_edge = (m_edge & ~clr) | (tog & ~m_sw);
            if (i_wr && i_addr == 2'd2) m_mask = i_wrdata[N-1:0];
            m_sw = m_sw ^ tog;
            for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = i_sw;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_o_sw", {8'h00, o_sw}, {8'h00, m_sw});
            chk("cyc_o_irq", {15'h0, o_irq}, {15'h0, |(m_edge & m_mask)});
            chk("cyc_o_rddata", o_rddata, m_rd);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
        i_rd = 1'b1; i_addr = a;
        step();
        i_rd = 1'b0;
        d = o_rddata;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
        i_wr = 1'b1; i_addr = a; i_wrdata = d;
        step();
        i_wr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d;
        step();
        started = 1'b1;
        repeat (2) step();
        chk("reset_o_sw", {8'h00, o_sw}, 16'h0000);
        chk("reset_rddata", o_rddata, 16'h0000);
        chk("reset_irq", {15'h0, o_irq}, 16'h0000);
        reset = 1'b0;

        // 3-cycle glitch on bit 5 must be rejected
        i_sw = 8'h20;
        repeat (3) step();
        i_sw = 8'h00;
        repeat (10) step();
        chk("glitch_o_sw", {8'h00, o_sw}, 16'h0000);
        bus_rd(2'd1, d);
        chk("glitch_edge", d, 16'h0000);

        // Bit 3 rises: visible exactly D+1 edges after the sampling edge
        i_sw = 8'h08;
        repeat (5) step();
        chk("lat_early_o_sw", {8'h00, o_sw}, 16'h0000);
        step();
        chk("lat_o_sw", {8'h00, o_sw}, 16'h0008);
        chk("model_sw", {8'h00, m_sw}, 16'h0008);
        bus_rd(2'd1, d);
        chk("rise_edge", d, 16'h0008);

        bus_wr(2'd2, 16'h0008);
        chk("irq_set", {15'h0, o_irq}, 16'h0001);
        bus_wr(2'd1, 16'h0008);
        chk("irq_clr", {15'h0, o_irq}, 16'h0000);
        bus_rd(2'd1, d);
        chk("w1c_edge", d, 16'h0000);

        // Bit 3 falls (no flag), bit 5 rises
        i_sw = 8'h20;
        repeat (10) step();
        chk("sw20_o_sw", {8'h00, o_sw}, 16'h0020);
        bus_rd(2'd0, d);
        chk("rd_data", d, 16'h0020);
        bus_rd(2'd3, d);
        chk("rd_rsvd", d, 16'h0000);
        bus_rd(2'd1, d);
        chk("fall_no_edge", d, 16'h0020);

        bus_wr(2'd0, 16'hffff);
        bus_wr(2'd3, 16'hffff);
        bus_rd(2'd2, d);
        chk("ro_mask", d, 16'h0008);
        bus_rd(2'd0, d);
        chk("ro_data", d, 16'h0020);

        // Simultaneous read and write returns the pre-write value
        i_rd = 1'b1; i_wr = 1'b1; i_addr = 2'd2; i_wrdata = 16'h00ff;
        step();
        i_rd = 1'b0; i_wr = 1'b0;
        chk("rdwr_old", o_rddata, 16'h0008);
        bus_rd(2'd2, d);
        chk("rdwr_new", d, 16'h00ff);

        // Clear of bit 3 on the same edge it rises: set wins
        i_sw = 8'h28;
        repeat (5) step();
        i_wr = 1'b1; i_addr = 2'd1; i_wrdata = 16'h0008;
        step();
        i_wr = 1'b0;
        chk("setwin_o_sw", {8'h00, o_sw}, 16'h0028);
        bus_rd(2'd1, d);
        chk("setwin_edge", d, 16'h0028);
        chk("setwin_irq", {15'h0, o_irq}, 16'h0001);

        // Reset in the middle of a bit-0 debounce
        i_sw = 8'h00;
        repeat (10) step();
        bus_wr(2'd1, 16'hffff);
        bus_rd(2'd1, d);
        chk("pre_rst_edge", d, 16'h0000);
        i_sw = 8'h01;
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();
        chk("midrst_o_sw", {8'h00, o_sw}, 16'h0000);
        chk("midrst_rddata", o_rddata, 16'h0000);
        chk("midrst_irq", {15'h0, o_irq}, 16'h0000);
        reset = 1'b0;
        repeat (5) step();
        chk("post_rst_early", {8'h00, o_sw}, 16'h0000);
        step();
        chk("post_rst_o_sw", {8'h00, o_sw}, 16'h0001);
        bus_rd(2'd1, d);
        chk("post_rst_edge", d, 16'h0001);

        // Randomized traffic checked by the model every cycle
        for (int cyc = 0; cyc < 4000; cyc++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 5) == 0)
                i_sw = i_sw ^ N'(1 << $urandom_range(0, N - 1));
            i_rd = ($urandom_range(0, 2) == 0);
            i_wr = ($urandom_range(0, 4) == 0);
            i_addr = 2'($urandom_range(0, 3));
            i_wrdata = 16'($urandom);
            step();
        end
        reset = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
